// File: rtl/gauss5x5_conv_if.sv
// gauss5x5_conv_if: window-in / pixel-out stream bundle (bypass present only with GAUSS_BYPASS_EN)
interface gauss5x5_conv_if;
  logic [199:0] window_in;
  logic         window_valid;
  logic         window_ready;
  logic         out_ready;
  logic [7:0]   pix_out;
  logic         pix_valid;
  logic [9:0]   out_col;
  logic [8:0]   out_row;
  logic         frame_done;
`ifdef GAUSS_BYPASS_EN
  logic         bypass;
  modport master (output window_in, window_valid, out_ready, bypass,
                  input window_ready, pix_out, pix_valid, out_col, out_row, frame_done);
  modport slave (input window_in, window_valid, out_ready, bypass,
                 output window_ready, pix_out, pix_valid, out_col, out_row, frame_done);
`else
  modport master (output window_in, window_valid, out_ready,
                  input window_ready, pix_out, pix_valid, out_col, out_row, frame_done);
  modport slave (input window_in, window_valid, out_ready,
                 output window_ready, pix_out, pix_valid, out_col, out_row, frame_done);
`endif
endinterface

// File: rtl/gauss5x5_conv.sv
// gauss5x5_conv: 3-stage 5x5 binomial Gaussian blur with raster tags; GAUSS_BYPASS_EN adds a per-window center-pixel bypass
module gauss5x5_conv #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic clk,
  input logic rst_n,
  gauss5x5_conv_if.slave w
);
  function automatic logic [11:0] hsum(input logic [39:0] r);
    return 12'(r[39:32]) + 12'(r[31:24]) * 12'd4 + 12'(r[23:16]) * 12'd6 +
           12'(r[15:8]) * 12'd4 + 12'(r[7:0]);
  endfunction
  logic        s1_v, s2_v, s1_byp, s2_byp, byp_in, pv, fd;
  logic [7:0]  s1_ctr, s2_ctr, po;
  logic [11:0] s1_h [5];
  logic [16:0] s2_sum, v_c;
  logic [17:0] rnd;
  logic        en1, en2, en3, xfer;
  logic [9:0]  col;
  logic [8:0]  row;
`ifdef GAUSS_BYPASS_EN
  assign byp_in = w.bypass;
`else
  assign byp_in = 1'b0;
`endif
  assign en3 = !pv || w.out_ready;
  assign en2 = !s2_v || en3;
  assign en1 = !s1_v || en2;
  assign xfer = pv && w.out_ready;
  assign v_c = 17'(s1_h[0]) + 17'(s1_h[1]) * 17'd4 + 17'(s1_h[2]) * 17'd6 +
               17'(s1_h[3]) * 17'd4 + 17'(s1_h[4]);
  assign rnd = 18'(s2_sum) + 18'd128;
  assign w.window_ready = en1;
  assign w.pix_valid = pv;
  assign w.pix_out = po;
  assign w.out_col = col;
  assign w.out_row = row;
  assign w.frame_done = fd;
  // S1: horizontal 1-4-6-4-1 sum of each window row, plus bypass tag and center pixel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_byp <= 1'b0;
      s1_ctr <= '0;
      s1_h <= '{default: '0};
    end else if (en1) begin
      s1_v <= w.window_valid;
      s1_byp <= byp_in;
      s1_ctr <= w.window_in[103:96];
      for (int i = 0; i < 5; i++) s1_h[i] <= hsum(w.window_in[199-40*i -: 40]);
    end
  // S2: vertical 1-4-6-4-1 sum of the row sums at full width
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s2_v <= 1'b0;
      s2_byp <= 1'b0;
      s2_ctr <= '0;
      s2_sum <= '0;
    end else if (en2) begin
      s2_v <= s1_v;
      s2_byp <= s1_byp;
      s2_ctr <= s1_ctr;
      s2_sum <= v_c;
    end
  // S3: round-to-nearest divide by 256 with saturation, or pass the center pixel on bypass
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pv <= 1'b0;
      po <= '0;
    end else if (en3) begin
      pv <= s2_v;
      po <= s2_byp ? s2_ctr : (|rnd[17:16] ? 8'hFF : rnd[15:8]);
    end
  // Raster position of the pixel on pix_out, advanced per downstream transfer; frame_done follows the last one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      fd <= 1'b0;
    end else begin
      fd <= xfer && col == 10'(IMG_W - 1) && row == 9'(IMG_H - 1);
      if (xfer) begin
        col <= col == 10'(IMG_W - 1) ? '0 : col + 10'd1;
        row <= col != 10'(IMG_W - 1) ? row : (row == 9'(IMG_H - 1) ? '0 : row + 9'd1);
      end
    end
endmodule

// File: tb/tb_gauss5x5_conv.sv
// tb_gauss5x5_conv: directed checks of gauss5x5_conv (IMG_W=4, IMG_H=2); honours GAUSS_BYPASS_EN
module tb_gauss5x5_conv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  gauss5x5_conv_if bif();
  gauss5x5_conv #(.IMG_W(4), .IMG_H(2)) dut (.clk(clk), .rst_n(rst_n), .w(bif));
  always #5 clk = ~clk;

  function automatic logic [199:0] uni(input logic [7:0] p);
    return {25{p}};
  endfunction

  function automatic logic [199:0] impulse();
    logic [199:0] x;
    x = '0;
    x[103:96] = 8'hFF;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bif.window_valid = 1'b0;
    bif.window_in = '0;
    bif.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_one(input logic [199:0] win, output logic [7:0] px, output logic v1,
                         output logic v2, output logic v3, output logic [9:0] c, output logic [8:0] r);
    bif.out_ready = 1'b1;
    bif.window_in = win;
    bif.window_valid = 1'b1;
    tick();
    bif.window_valid = 1'b0;
    v1 = bif.pix_valid;
    tick();
    v2 = bif.pix_valid;
    tick();
    v3 = bif.pix_valid;
    px = bif.pix_out;
    c = bif.out_col;
    r = bif.out_row;
    tick();
  endtask

  task automatic send_stream(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      logic acc;
      int guard;
      bif.window_valid = 1'b1;
      bif.window_in = uni(8'(base + 8'(13 * i)));
      guard = 0;
      do begin
        @(negedge clk);
        acc = bif.window_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!acc && guard < 100);
      if (!acc) begin
        failures++;
        $display("FAIL send_timeout window %0d not accepted in 100 cycles", i);
      end
    end
    bif.window_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (bif.pix_valid !== 1'b0) begin failures++; $display("FAIL reset_pix_valid got %b want 0", bif.pix_valid); end
    if (bif.pix_out !== 8'h00) begin failures++; $display("FAIL reset_pix_out got %h want 00", bif.pix_out); end
    if (bif.out_col !== 10'd0) begin failures++; $display("FAIL reset_col got %0d want 0", bif.out_col); end
    if (bif.out_row !== 9'd0) begin failures++; $display("FAIL reset_row got %0d want 0", bif.out_row); end
    if (bif.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got %b want 0", bif.frame_done); end
    if (bif.window_ready !== 1'b1) begin failures++; $display("FAIL reset_window_ready got %b want 1", bif.window_ready); end
    do_reset();
  endtask

  task automatic test_uniform();
    logic [7:0] px;
    logic v1, v2, v3;
    logic [9:0] c;
    logic [8:0] r;
    run_one(uni(8'h80), px, v1, v2, v3, c, r);
    checks += 3;
    if (v1 !== 1'b0 || v2 !== 1'b0) begin failures++; $display("FAIL uniform_early got v1=%b v2=%b want 0 0", v1, v2); end
    if (v3 !== 1'b1) begin failures++; $display("FAIL uniform_latency got pix_valid=%b want 1 at clk 3", v3); end
    if (px !== 8'h80) begin failures++; $display("FAIL uniform_pix got %h want 80", px); end
  endtask

  task automatic test_impulse();
    logic [7:0] px;
    logic v1, v2, v3;
    logic [9:0] c;
    logic [8:0] r;
    run_one(impulse(), px, v1, v2, v3, c, r);
    checks += 2;
    if (v3 !== 1'b1) begin failures++; $display("FAIL impulse_valid got %b want 1", v3); end
    if (px !== 8'h24) begin failures++; $display("FAIL impulse_pix got %h want 24", px); end
  endtask

  task automatic test_saturation();
    logic [7:0] px;
    logic v1, v2, v3;
    logic [9:0] c;
    logic [8:0] r;
    run_one(uni(8'hFF), px, v1, v2, v3, c, r);
    checks++;
    if (px !== 8'hFF) begin failures++; $display("FAIL sat_full_pix got %h want FF", px); end
    run_one({80'h0, {15{8'hFF}}}, px, v1, v2, v3, c, r);
    checks++;
    if (px !== 8'hAF) begin failures++; $display("FAIL sat_pad_pix got %h want AF", px); end
  endtask

  task automatic test_backpressure();
    int n;
    n = 0;
    do_reset();
    fork
      send_stream(10, 8'h05);
      begin
        logic stall_prev;
        logic [7:0] held;
        logic [7:0] exp_px;
        int c;
        stall_prev = 1'b0;
        held = '0;
        c = 0;
        while (n < 10 && c < 200) begin
          bif.out_ready = c < 8 ? !c[0] : c < 13 ? 1'b0 : c < 20 ? c[0] : 1'b1;
          @(negedge clk);
          if (bif.pix_valid) begin
            if (stall_prev) begin
              checks++;
              if (bif.pix_out !== held) begin failures++; $display("FAIL bp_stable got %h want %h", bif.pix_out, held); end
            end
            if (bif.out_ready) begin
              exp_px = 8'(8'h05 + 8'(13 * n));
              checks++;
              if (bif.pix_out !== exp_px) begin failures++; $display("FAIL bp_order idx %0d got %h want %h", n, bif.pix_out, exp_px); end
              n++;
              stall_prev = 1'b0;
            end else if (!stall_prev) begin
              stall_prev = 1'b1;
              held = bif.pix_out;
            end
          end
          @(posedge clk);
          #1;
          c++;
        end
      end
    join
    checks++;
    if (n !== 10) begin failures++; $display("FAIL bp_count got %0d want 10", n); end
    bif.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bif.pix_valid !== 1'b0) begin failures++; $display("FAIL bp_duplicate got pix_valid=%b want 0", bif.pix_valid); end
    end
  endtask

  task automatic test_framing();
    int k;
    int pulses;
    k = 0;
    pulses = 0;
    do_reset();
    bif.out_ready = 1'b1;
    fork
      send_stream(16, 8'h10);
      begin
        logic fd_exp;
        fd_exp = 1'b0;
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          checks++;
          if (bif.frame_done !== fd_exp) begin failures++; $display("FAIL frame_done cycle %0d got %b want %b", c, bif.frame_done, fd_exp); end
          if (bif.frame_done === 1'b1) pulses++;
          fd_exp = bif.pix_valid && bif.out_ready && (k == 7 || k == 15);
          if (bif.pix_valid && bif.out_ready) begin
            checks++;
            if (bif.out_col !== 10'(k % 4) || bif.out_row !== 9'((k / 4) % 2)) begin
              failures++;
              $display("FAIL frame_tag idx %0d got (%0d,%0d) want (%0d,%0d)", k, bif.out_col, bif.out_row, k % 4, (k / 4) % 2);
            end
            k++;
          end
          @(posedge clk);
          #1;
        end
      end
    join
    checks += 3;
    if (k !== 16) begin failures++; $display("FAIL frame_count got %0d want 16", k); end
    if (pulses !== 2) begin failures++; $display("FAIL frame_pulses got %0d want 2", pulses); end
    if (bif.out_col !== 10'd0 || bif.out_row !== 9'd0) begin failures++; $display("FAIL frame_wrap got (%0d,%0d) want (0,0)", bif.out_col, bif.out_row); end
  endtask

  task automatic test_midframe_reset();
    logic [7:0] px;
    logic v1, v2, v3;
    logic [9:0] c;
    logic [8:0] r;
    int stray;
    do_reset();
    bif.out_ready = 1'b1;
    send_stream(2, 8'h20);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bif.out_col !== 10'd2) begin failures++; $display("FAIL mid_col_before got %0d want 2", bif.out_col); end
    bif.out_ready = 1'b0;
    send_stream(2, 8'h40);
    tick();
    checks++;
    if (bif.pix_valid !== 1'b1) begin failures++; $display("FAIL mid_inflight got pix_valid=%b want 1", bif.pix_valid); end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (bif.pix_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got %b want 0", bif.pix_valid); end
    if (bif.out_col !== 10'd0 || bif.out_row !== 9'd0) begin failures++; $display("FAIL mid_reset_pos got (%0d,%0d) want (0,0)", bif.out_col, bif.out_row); end
    if (bif.window_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got %b want 1", bif.window_ready); end
    tick();
    rst_n = 1'b1;
    bif.out_ready = 1'b1;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bif.pix_valid) stray++;
    end
    checks++;
    if (stray !== 0) begin failures++; $display("FAIL mid_discard got %0d stray pixels want 0", stray); end
    run_one(impulse(), px, v1, v2, v3, c, r);
    checks += 2;
    if (px !== 8'h24 || v3 !== 1'b1) begin failures++; $display("FAIL mid_next_pix got %h valid=%b want 24 valid=1", px, v3); end
    if (c !== 10'd0 || r !== 9'd0) begin failures++; $display("FAIL mid_next_tag got (%0d,%0d) want (0,0)", c, r); end
  endtask

`ifdef GAUSS_BYPASS_EN
  task automatic test_bypass();
    logic [7:0] px;
    logic v1, v2, v3;
    logic [9:0] c;
    logic [8:0] r;
    bif.bypass = 1'b1;
    run_one(impulse(), px, v1, v2, v3, c, r);
    bif.bypass = 1'b0;
    checks += 2;
    if (v1 !== 1'b0 || v2 !== 1'b0 || v3 !== 1'b1) begin failures++; $display("FAIL bypass_latency got %b%b%b want 001", v1, v2, v3); end
    if (px !== 8'hFF) begin failures++; $display("FAIL bypass_pix got %h want FF", px); end
    run_one(impulse(), px, v1, v2, v3, c, r);
    checks++;
    if (px !== 8'h24) begin failures++; $display("FAIL bypass_off_pix got %h want 24", px); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef GAUSS_BYPASS_EN
    bif.bypass = 1'b0;
`endif
    bif.window_valid = 1'b0;
    bif.window_in = '0;
    bif.out_ready = 1'b0;
    test_reset();
    test_uniform();
    test_impulse();
    test_saturation();
    test_backpressure();
    test_framing();
    test_midframe_reset();
`ifdef GAUSS_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
